argon_ctrl_seq: RTL
===================

// Module: argon_ctrl_seq
// PURPOSE
//  Control sequencer (initiator) for the Argon datapath bus. Accepts one ALU micro-op
//  command via valid/ready. Drives the RegFile/ALU control strobes and the shared
//  16-bit bus through a fixed sequence: select regs, read A, read B, load op,
//  execute, write back. Returns result, done and error to the issuing front end.
// PARAMETERS
//  DATA_W      16  bus/data width
//  REG_W       4   register index width; sel word = {rd, rs2, rs1} zero-extended
//  OP_W        4   ALU opcode width
//  EXE_CYCLES  1   ALU wait cycles in EXE (legal >=1; 0 is a config error)
// PORTS
//  i_Clk          in   1       clock, rising edge
//  i_Reset        in   1       async reset, active-high
//  i_cmd_valid    in   1       command valid
//  o_cmd_ready    out  1       high only in IDLE
//  i_cmd_op       in   OP_W    ALU opcode
//  i_cmd_rd/rs1/rs2 in REG_W   dest / source A / source B register index
//  i_abort        in   1       sync abort of an in-flight command
//  i_bus          in   DATA_W  shared bus as driven by the responders
//  i_bus_valid    in   1       some responder (RegFile or ALU) is driving i_bus
//  o_bus          out  DATA_W  sequencer bus drive (0 when not driving)
//  o_bus_valid    out  1       sequencer is driving o_bus
//  o_selectLatch, o_outputA, o_outputB, o_latchC                 out 1  RegFile strobes
//  o_latchA, o_latchB, o_latchF, o_latchOp, o_outputY, o_outputF out 1  ALU strobes
//  o_result       out  DATA_W  value captured in WB
//  o_flags        out  DATA_W  flags captured in FLG (ARGON_SEQ_FLAGS_EN only)
//  o_done         out  1       1-cycle pulse, command complete
//  o_err          out  1       sticky; cleared on next accepted command
// BEHAVIOUR
//  - Reset (async): state=IDLE; all strobes, o_bus_valid, o_done, o_err =0.
//    o_bus, o_result, o_flags =0. Strobes drop immediately, not at the next edge.
//  - Accept on the edge where i_cmd_valid & o_cmd_ready & !i_abort.
//    Fields are registered at accept; the command is ignored while busy.
//  - States after accept, one cycle each unless noted; strobes are Moore outputs:
//    SEL : o_bus={rd,rs2,rs1} zero-ext, o_bus_valid=1, o_selectLatch=1
//    RDA : o_outputA=1, o_latchA=1
//    RDB : o_outputB=1, o_latchB=1
//    OP  : o_bus={0,op}, o_bus_valid=1, o_latchOp=1
//    EXE : no strobes; down-counter loaded with EXE_CYCLES, leave when it hits 1
//    WB  : o_outputY=1, o_latchC=1; o_result<=i_bus at end of cycle
//    FLG : (macro only) o_outputF=1; o_flags<=i_bus
//    then IDLE. o_done=1 in the first IDLE cycle; o_cmd_ready also 1 there.
//  - Latency, accept edge to o_done high: 6+EXE_CYCLES cycles (+1 with FLG).
//    Back-to-back: a new accept is allowed in the o_done cycle.
//  - At most one strobe group active per cycle; o_bus_valid only in SEL and OP.
//  - Error checks (any one sets o_err, sequence continues):
//    i_bus_valid=1 in SEL/OP (contention); i_bus_valid=0 in RDA/RDB/WB/FLG (no responder).
//  - i_abort in a non-IDLE state: next cycle IDLE, strobes low.
//    No o_done; o_result is unchanged unless WB has already completed.
//    i_abort in IDLE blocks acceptance.
//  - Reset mid-sequence: same as reset; no o_done is produced.
// CONFIGURATION
//  ARGON_SEQ_FLAGS_EN defined: FLG state present.
//    o_flags is updated and latency is 7+EXE_CYCLES.
//  ARGON_SEQ_FLAGS_EN undefined: no FLG state; o_flags tied to 0; o_outputF held 0.
//    o_latchF is held 0 in both builds (reserved for a flag-restore op).
// TESTING
//  T1 rd=3,rs1=1,rs2=2,op=4'h1, responders drive 0x0005 in WB ->
//     SEL bus=0x0321, o_result=0x0005, o_done at cycle 7 (EXE_CYCLES=1), o_err=0.
//  T2 two back-to-back cmds, valid held high ->
//     2nd accepted in 1st o_done cycle; strobe trace repeats with no gap.
//  T3 i_bus_valid held 1 during OP ->
//     o_err=1 at done; next accept clears o_err.
//  T4 i_abort asserted in EXE ->
//     IDLE next cycle, no o_done, o_result unchanged, o_cmd_ready=1.
//  T5 i_Reset pulsed mid-RDB (between edges) ->
//     all strobes 0 immediately; after release o_cmd_ready=1, no o_done.
//  T6 FLAGS_EN build, EXE_CYCLES=3, flags bus 0x000A ->
//     o_flags=0x000A, o_done at cycle 10; non-FLAGS build o_done at cycle 9.

Source files
------------

// File: rtl/argon_ctrl_seq.sv
// argon_ctrl_seq: control sequencer (initiator) for the Argon datapath bus.
// Takes one ALU micro-op over valid/ready and walks the RegFile/ALU strobes
// through SEL -> RDA -> RDB -> OP -> EXE -> WB (-> FLG) -> IDLE, then reports
// result, a one-cycle done pulse and a sticky error flag.
// Optional build macro: ARGON_SEQ_FLAGS_EN adds the FLG state and drives o_flags.
module argon_ctrl_seq #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 4,
    parameter int OP_W       = 4,
    parameter int EXE_CYCLES = 1
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [OP_W-1:0]   i_cmd_op,
    input  logic [REG_W-1:0]  i_cmd_rd,
    input  logic [REG_W-1:0]  i_cmd_rs1,
    input  logic [REG_W-1:0]  i_cmd_rs2,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_bus,
    input  logic              i_bus_valid,
    output logic [DATA_W-1:0] o_bus,
    output logic              o_bus_valid,
    output logic              o_selectLatch,
    output logic              o_outputA,
    output logic              o_outputB,
    output logic              o_latchC,
    output logic              o_latchA,
    output logic              o_latchB,
    output logic              o_latchF,
    output logic              o_latchOp,
    output logic              o_outputY,
    output logic              o_outputF,
    output logic [DATA_W-1:0] o_result,
    output logic [DATA_W-1:0] o_flags,
    output logic              o_done,
    output logic              o_err
);

    localparam int CNT_W = (EXE_CYCLES > 1) ? $clog2(EXE_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_RDA  = 3'd2,
        S_RDB  = 3'd3,
        S_OP   = 3'd4,
        S_EXE  = 3'd5,
        S_WB   = 3'd6
`ifdef ARGON_SEQ_FLAGS_EN
        ,
        S_FLG  = 3'd7
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [REG_W-1:0]    rd_q, rd_d;
    logic [REG_W-1:0]    rs1_q, rs1_d;
    logic [REG_W-1:0]    rs2_q, rs2_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;
    logic [DATA_W-1:0]   sel_word;
    logic [DATA_W-1:0]   op_word;

    assign o_cmd_ready = (state_q == S_IDLE);
    assign accept      = o_cmd_ready && i_cmd_valid && !i_abort;
    assign sel_word    = DATA_W'({rd_q, rs2_q, rs1_q});
    assign op_word     = DATA_W'(op_q);
    assign o_result    = result_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_latchF    = 1'b0;

`ifdef ARGON_SEQ_FLAGS_EN
    logic [DATA_W-1:0] flags_q, flags_d;
    assign o_flags = flags_q;
`else
    assign o_flags = '0;
`endif

    // Next-state, command capture, EXE countdown, error and capture logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = err_q;
`ifdef ARGON_SEQ_FLAGS_EN
        flags_d  = flags_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SEL;
                    op_d    = i_cmd_op;
                    rd_d    = i_cmd_rd;
                    rs1_d   = i_cmd_rs1;
                    rs2_d   = i_cmd_rs2;
                    err_d   = 1'b0;
                end
            end
            S_SEL: begin
                if (i_bus_valid) err_d = 1'b1;
                state_d = S_RDA;
            end
            S_RDA: begin
                if (!i_bus_valid) err_d = 1'b1;
                state_d = S_RDB;
            end
            S_RDB: begin
                if (!i_bus_valid) err_d = 1'b1;
                state_d = S_OP;
            end
            S_OP: begin
                if (i_bus_valid) err_d = 1'b1;
                state_d = S_EXE;
                cnt_d   = CNT_W'(EXE_CYCLES);
            end
            S_EXE: begin
                // "<= 1" also lets an illegal EXE_CYCLES of 0 fall through after one cycle
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WB: begin
                if (!i_bus_valid) err_d = 1'b1;
                result_d = i_bus;
`ifdef ARGON_SEQ_FLAGS_EN
                state_d = S_FLG;
`else
                state_d = S_IDLE;
                done_d  = 1'b1;
`endif
            end
`ifdef ARGON_SEQ_FLAGS_EN
            S_FLG: begin
                if (!i_bus_valid) err_d = 1'b1;
                flags_d = i_bus;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Abort overrides the step: no done, and a capture in this cycle is dropped
        if ((state_q != S_IDLE) && i_abort) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
`ifdef ARGON_SEQ_FLAGS_EN
            flags_d  = flags_q;
`endif
        end
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ARGON_SEQ_FLAGS_EN
            flags_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef ARGON_SEQ_FLAGS_EN
            flags_q  <= flags_d;
`endif
        end
    end

    // Moore decode of strobes and bus drive from the current state
    always_comb begin
        o_bus         = '0;
        o_bus_valid   = 1'b0;
        o_selectLatch = 1'b0;
        o_outputA     = 1'b0;
        o_outputB     = 1'b0;
        o_latchC      = 1'b0;
        o_latchA      = 1'b0;
        o_latchB      = 1'b0;
        o_latchOp     = 1'b0;
        o_outputY     = 1'b0;
        o_outputF     = 1'b0;
        case (state_q)
            S_SEL: begin
                o_bus         = sel_word;
                o_bus_valid   = 1'b1;
                o_selectLatch = 1'b1;
            end
            S_RDA: begin
                o_outputA = 1'b1;
                o_latchA  = 1'b1;
            end
            S_RDB: begin
                o_outputB = 1'b1;
                o_latchB  = 1'b1;
            end
            S_OP: begin
                o_bus       = op_word;
                o_bus_valid = 1'b1;
                o_latchOp   = 1'b1;
            end
            S_WB: begin
                o_outputY = 1'b1;
                o_latchC  = 1'b1;
            end
`ifdef ARGON_SEQ_FLAGS_EN
            S_FLG: begin
                o_outputF = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
